datamem_sized: RTL and testbench

- Parametrised successor to the single-cycle word data memory in the MIPS datapath.
- Adds byte/halfword/word stores with lane merge, sign/zero-extended sub-word loads and a configurable read latency with a busy/valid handshake.
- Adds misalignment detection and asynchronous reset.
- Sits between the EX/MEM stage and the MEM/WB register; the MEM stage stalls while busy is high.

---
 rtl/datamem_sized.sv | 208 ++++++++++++++++++++
 tb/tb_datamem_sized.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/datamem_sized.sv
// Data memory for the MEM stage: byte/half/word stores with lane merge, extended sub-word
// loads, misalignment detection and a configurable read latency behind a busy/valid handshake.
module datamem_sized #(
    parameter int ADDR_WIDTH   = 5,
    parameter int READ_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    input  logic [1:0]  size,
    input  logic        signExt,
    output logic [31:0] readData,
    output logic        readValid,
    output logic        busy,
    output logic        misaligned
);

    // state | meaning
    // IDLE  | ready; requests accepted, latency-1 reads answered next cycle
    // WAIT  | multi-cycle read in flight; cnt_q counts the remaining busy cycles
    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    localparam int         DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [1:0] CNT_LOAD = 2'(READ_LATENCY - 1);

    function automatic logic [31:0] extract(
        input logic [31:0] word,
        input logic [1:0]  sz,
        input logic [1:0]  lane,
        input logic        sx
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (sz)
            2'b00:   r = {{24{sx & b[7]}}, b};
            2'b01:   r = {{16{sx & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    state_t                  state_q, state_d;
    logic [1:0]              cnt_q, cnt_d;
    logic [31:0]             read_data_q, read_data_d;
    logic                    read_valid_q, read_valid_d;
    logic                    misaligned_q, misaligned_d;
    logic [31:0]             rd_word_q, rd_word_d;
    logic [1:0]              rd_size_q, rd_size_d;
    logic [1:0]              rd_lane_q, rd_lane_d;
    logic                    rd_sext_q, rd_sext_d;
    logic [31:0]             mem_q [DEPTH];
    logic [31:0]             mem_d [DEPTH];

    logic                    accept;
    logic                    is_misaligned;
    logic                    do_write;
    logic                    do_read;
    logic [ADDR_WIDTH-1:0]   word_idx;
    logic [3:0]              wr_be;
    logic [31:0]             wr_lanes;
    logic                    unused_addr;

    assign unused_addr = ^address[31:ADDR_WIDTH+2];

    assign busy       = (state_q == WAIT);
    assign readData   = read_data_q;
    assign readValid  = read_valid_q;
    assign misaligned = misaligned_q;

    assign word_idx = address[ADDR_WIDTH+1:2];
    assign accept   = !busy && (memRead || memWrite);

    always_comb begin
        is_misaligned = 1'b0;
        case (size)
            2'b00:   is_misaligned = 1'b0;
            2'b01:   is_misaligned = address[0];
            default: is_misaligned = (address[1:0] != 2'b00);
        endcase
    end

    // A simultaneous read and write performs only the write.
    assign do_write = accept && memWrite && !is_misaligned;
    assign do_read  = accept && memRead && !memWrite && !is_misaligned;

    always_comb begin
        wr_be    = 4'b0000;
        wr_lanes = writeData;
        case (size)
            2'b00: begin
                wr_be    = 4'b0001 << address[1:0];
                wr_lanes = {4{writeData[7:0]}};
            end
            2'b01: begin
                wr_be    = address[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{writeData[15:0]}};
            end
            default: begin
                wr_be    = 4'b1111;
                wr_lanes = writeData;
            end
        endcase
    end

    always_comb begin
        mem_d = mem_q;
        if (do_write) begin
            for (int l = 0; l < 4; l++) begin
                if (wr_be[l]) begin
                    mem_d[word_idx][8*l +: 8] = wr_lanes[8*l +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        read_data_d  = read_data_q;
        read_valid_d = 1'b0;
        misaligned_d = accept && is_misaligned;
        rd_word_d    = rd_word_q;
        rd_size_d    = rd_size_q;
        rd_lane_d    = rd_lane_q;
        rd_sext_d    = rd_sext_q;
        case (state_q)
            IDLE: begin
                if (do_read) begin
                    if (READ_LATENCY == 1) begin
                        read_valid_d = 1'b1;
                        read_data_d  = extract(mem_q[word_idx], size, address[1:0], signExt);
                    end else begin
                        state_d   = WAIT;
                        cnt_d     = CNT_LOAD;
                        rd_word_d = mem_q[word_idx];
                        rd_size_d = size;
                        rd_lane_d = address[1:0];
                        rd_sext_d = signExt;
                    end
                end
            end
            WAIT: begin
                // The edge that takes the counter to zero delivers the result.
                if (cnt_q <= 2'd1) begin
                    state_d      = IDLE;
                    cnt_d        = 2'd0;
                    read_valid_d = 1'b1;
                    read_data_d  = extract(rd_word_q, rd_size_q, rd_lane_q, rd_sext_q);
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 2'd0;
            read_data_q  <= 32'd0;
            read_valid_q <= 1'b0;
            misaligned_q <= 1'b0;
            rd_word_q    <= 32'd0;
            rd_size_q    <= 2'd0;
            rd_lane_q    <= 2'd0;
            rd_sext_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
            misaligned_q <= misaligned_d;
            rd_word_q    <= rd_word_d;
            rd_size_q    <= rd_size_d;
            rd_lane_q    <= rd_lane_d;
            rd_sext_q    <= rd_sext_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: tb/tb_datamem_sized.sv
// Bench for datamem_sized: three latencies (1, 3, 4) share stimulus; a reference model
// queues expected load results at acceptance and they are popped on each readValid.
module tb_datamem_sized;

    logic        clock;
    logic        reset;
    logic        memRead;
    logic        memWrite;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [1:0]  size;
    logic        signExt;

    logic [31:0] rd_data  [3];
    logic        rd_valid [3];
    logic        dut_busy [3];
    logic        dut_mis  [3];

    int          lat [3] = '{1, 3, 4};

    int          n_tests = 0;
    int          n_fail  = 0;

    logic [31:0] m_mem  [3][32];
    int          m_pend [3];
    bit          m_val  [3];
    bit          m_mis  [3];
    logic [31:0] sb_q   [3][$];

    int          v_cnt   [3];
    int          mis_cnt [3];

    datamem_sized #(.ADDR_WIDTH(5), .READ_LATENCY(1)) u_dut_l1 (
        .clock(clock), .reset(reset), .memRead(memRead), .memWrite(memWrite),
        .address(address), .writeData(writeData), .size(size), .signExt(signExt),
        .readData(rd_data[0]), .readValid(rd_valid[0]), .busy(dut_busy[0]),
        .misaligned(dut_mis[0])
    );

    datamem_sized #(.ADDR_WIDTH(5), .READ_LATENCY(3)) u_dut_l3 (
        .clock(clock), .reset(reset), .memRead(memRead), .memWrite(memWrite),
        .address(address), .writeData(writeData), .size(size), .signExt(signExt),
        .readData(rd_data[1]), .readValid(rd_valid[1]), .busy(dut_busy[1]),
        .misaligned(dut_mis[1])
    );

    datamem_sized #(.ADDR_WIDTH(5), .READ_LATENCY(4)) u_dut_l4 (
        .clock(clock), .reset(reset), .memRead(memRead), .memWrite(memWrite),
        .address(address), .writeData(writeData), .size(size), .signExt(signExt),
        .readData(rd_data[2]), .readValid(rd_valid[2]), .busy(dut_busy[2]),
        .misaligned(dut_mis[2])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit mdl_misaligned(input logic [31:0] a, input logic [1:0] s);
        if (s == 2'b00) return 1'b0;
        if (s == 2'b01) return a[0];
        return a[1:0] != 2'b00;
    endfunction

    function automatic logic [31:0] mdl_merge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [31:0] a, input logic [1:0] s);
        logic [31:0] r;
        r = old;
        if (s == 2'b00)      r[8*a[1:0] +: 8]  = wd[7:0];
        else if (s == 2'b01) r[16*a[1] +: 16]  = wd[15:0];
        else                 r = wd;
        return r;
    endfunction

    function automatic logic [31:0] mdl_load(input logic [31:0] w, input logic [31:0] a,
                                             input logic [1:0] s, input bit sx);
        logic [31:0] sh;
        if (s == 2'b00) begin
            sh = w >> (8 * a[1:0]);
            return sx ? {{24{sh[7]}}, sh[7:0]} : {24'd0, sh[7:0]};
        end
        if (s == 2'b01) begin
            sh = w >> (16 * a[1]);
            return sx ? {{16{sh[15]}}, sh[15:0]} : {16'd0, sh[15:0]};
        end
        return w;
    endfunction

    // Reference model: one copy of state per latency instance.
    always @(posedge clock or posedge reset) begin
        bit acc;
        int idx;
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                m_pend[i] = 0;
                m_val[i]  = 1'b0;
                m_mis[i]  = 1'b0;
                sb_q[i].delete();
                for (int j = 0; j < 32; j++) m_mem[i][j] = 32'd0;
            end else begin
                acc = (m_pend[i] == 0) && (memRead || memWrite);
                idx = int'(address[6:2]);
                m_val[i] = 1'b0;
                m_mis[i] = 1'b0;
                if (m_pend[i] > 0) begin
                    m_pend[i]--;
                    if (m_pend[i] == 0) m_val[i] = 1'b1;
                end
                if (acc) begin
                    if (mdl_misaligned(address, size)) begin
                        m_mis[i] = 1'b1;
                    end else if (memWrite) begin
                        m_mem[i][idx] = mdl_merge(m_mem[i][idx], writeData, address, size);
                    end else begin
                        sb_q[i].push_back(mdl_load(m_mem[i][idx], address, size, signExt));
                        if (lat[i] == 1) m_val[i] = 1'b1;
                        else             m_pend[i] = lat[i] - 1;
                    end
                end
            end
        end
    end

    always @(negedge clock) begin
        logic [31:0] exp;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("busy_l%0d", lat[i]), 32'(dut_busy[i]), 32'(m_pend[i] != 0));
            chk($sformatf("valid_l%0d", lat[i]), 32'(rd_valid[i]), 32'(m_val[i]));
            chk($sformatf("mis_l%0d", lat[i]), 32'(dut_mis[i]), 32'(m_mis[i]));
            if (rd_valid[i] === 1'b1) begin
                v_cnt[i]++;
                chk($sformatf("sb_nonempty_l%0d", lat[i]), 32'(sb_q[i].size() != 0), 32'd1);
                if (sb_q[i].size() != 0) begin
                    exp = sb_q[i].pop_front();
                    chk($sformatf("rdata_l%0d", lat[i]), rd_data[i], exp);
                end
            end
            if (dut_mis[i] === 1'b1) mis_cnt[i]++;
        end
    end

    task automatic req(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] s, input bit sx);
        @(negedge clock);
        memRead   = rd;
        memWrite  = wr;
        address   = a;
        writeData = wd;
        size      = s;
        signExt   = sx;
        @(negedge clock);
        memRead  = 1'b0;
        memWrite = 1'b0;
    endtask

    task automatic settle();
        repeat (6) @(negedge clock);
    endtask

    task automatic wr_req(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] s);
        req(1'b0, 1'b1, a, wd, s, 1'b0);
        settle();
    endtask

    task automatic rd_check(input string tag, input logic [31:0] a, input logic [1:0] s,
                            input bit sx, input logic [31:0] exp);
        int v0 [3];
        for (int i = 0; i < 3; i++) v0[i] = v_cnt[i];
        req(1'b1, 1'b0, a, 32'd0, s, sx);
        settle();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_l%0d", tag, lat[i]), rd_data[i], exp);
            chk($sformatf("%s_pulses_l%0d", tag, lat[i]), 32'(v_cnt[i] - v0[i]), 32'd1);
        end
    endtask

    initial begin
        int v0 [3];
        int m0 [3];
        bit exp_b;
        bit exp_v;

        reset     = 1'b1;
        memRead   = 1'b0;
        memWrite  = 1'b0;
        address   = 32'd0;
        writeData = 32'd0;
        size      = 2'b10;
        signExt   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            v_cnt[i]   = 0;
            mis_cnt[i] = 0;
        end
        repeat (3) @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            chk("reset_rdata", rd_data[i], 32'd0);
            chk("reset_valid", 32'(rd_valid[i]), 32'd0);
            chk("reset_busy", 32'(dut_busy[i]), 32'd0);
            chk("reset_mis", 32'(dut_mis[i]), 32'd0);
        end
        #2 reset = 1'b0;
        settle();

        // Lane merge: byte store into the top lane of a word.
        wr_req(32'h08, 32'hDEADBEEF, 2'b10);
        wr_req(32'h0B, 32'h0000007F, 2'b00);
        rd_check("merge", 32'h08, 2'b10, 1'b0, 32'h7FADBEEF);

        // Extension.
        wr_req(32'h08, 32'h000080A5, 2'b10);
        rd_check("lb_sx", 32'h09, 2'b00, 1'b1, 32'hFFFFFF80);
        rd_check("lbu", 32'h09, 2'b00, 1'b0, 32'h00000080);
        rd_check("lh_sx", 32'h08, 2'b01, 1'b1, 32'hFFFF80A5);
        rd_check("lbu_l0", 32'h08, 2'b00, 1'b0, 32'h000000A5);
        rd_check("lb_sx_l0", 32'h08, 2'b00, 1'b1, 32'hFFFFFFA5);
        wr_req(32'h0E, 32'h0000F00F, 2'b01);
        rd_check("lh_hi", 32'h0E, 2'b01, 1'b1, 32'hFFFFF00F);
        rd_check("lw_half_merge", 32'h0C, 2'b11, 1'b0, 32'hF00F0000);

        // Misaligned half read and word write.
        wr_req(32'h04, 32'hCAFEF00D, 2'b10);
        for (int i = 0; i < 3; i++) begin
            v0[i] = v_cnt[i];
            m0[i] = mis_cnt[i];
        end
        req(1'b1, 1'b0, 32'h03, 32'd0, 2'b01, 1'b1);
        settle();
        req(1'b0, 1'b1, 32'h06, 32'h11111111, 2'b10, 1'b0);
        settle();
        for (int i = 0; i < 3; i++) begin
            chk("mis_pulses", 32'(mis_cnt[i] - m0[i]), 32'd2);
            chk("mis_no_valid", 32'(v_cnt[i] - v0[i]), 32'd0);
        end
        rd_check("mis_unchanged", 32'h04, 2'b10, 1'b0, 32'hCAFEF00D);

        // Aliasing above the depth.
        wr_req(32'h80, 32'h12345678, 2'b10);
        rd_check("alias", 32'h00, 2'b10, 1'b0, 32'h12345678);

        // Write at edge k, read of the same word at edge k+1.
        for (int i = 0; i < 3; i++) v0[i] = v_cnt[i];
        @(negedge clock);
        memWrite  = 1'b1;
        address   = 32'h10;
        writeData = 32'h55AA33CC;
        size      = 2'b10;
        @(negedge clock);
        memWrite = 1'b0;
        memRead  = 1'b1;
        @(negedge clock);
        memRead = 1'b0;
        settle();
        for (int i = 0; i < 3; i++) begin
            chk("wr_then_rd", rd_data[i], 32'h55AA33CC);
            chk("wr_then_rd_pulses", 32'(v_cnt[i] - v0[i]), 32'd1);
        end

        // Held read on the latency-4 instance.
        @(negedge clock);
        memRead = 1'b1;
        address = 32'h08;
        size    = 2'b10;
        signExt = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            exp_b = (c >= 1 && c <= 3) || (c >= 5 && c <= 7);
            exp_v = (c == 4) || (c == 8);
            chk($sformatf("hs_busy_c%0d", c), 32'(dut_busy[2]), 32'(exp_b));
            chk($sformatf("hs_valid_c%0d", c), 32'(rd_valid[2]), 32'(exp_v));
            if (exp_v) chk($sformatf("hs_rdata_c%0d", c), rd_data[2], 32'h000080A5);
            if (c == 6) memRead = 1'b0;
        end
        settle();

        // Simultaneous read and write: only the write happens.
        for (int i = 0; i < 3; i++) v0[i] = v_cnt[i];
        req(1'b1, 1'b1, 32'h14, 32'hA5A5A5A5, 2'b10, 1'b0);
        settle();
        for (int i = 0; i < 3; i++) chk("rw_no_valid", 32'(v_cnt[i] - v0[i]), 32'd0);
        rd_check("rw_write_lands", 32'h14, 2'b10, 1'b0, 32'hA5A5A5A5);

        // Reset one cycle after a read is accepted.
        @(negedge clock);
        memRead = 1'b1;
        address = 32'h08;
        size    = 2'b10;
        @(negedge clock);
        memRead = 1'b0;
        chk("pre_reset_busy_l3", 32'(dut_busy[1]), 32'd1);
        #2 reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("mid_reset_busy", 32'(dut_busy[i]), 32'd0);
            chk("mid_reset_valid", 32'(rd_valid[i]), 32'd0);
            v0[i] = v_cnt[i];
        end
        @(negedge clock);
        #2 reset = 1'b0;
        repeat (8) @(negedge clock);
        for (int i = 0; i < 3; i++) chk("abort_no_valid", 32'(v_cnt[i] - v0[i]), 32'd0);
        rd_check("post_reset_w0", 32'h00, 2'b10, 1'b0, 32'h00000000);
        rd_check("post_reset_w2", 32'h08, 2'b10, 1'b0, 32'h00000000);

        for (int i = 0; i < 3; i++)
            chk("sb_drained", 32'(sb_q[i].size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_tests++;
        n_fail++;
        $display("FAIL timeout: bench did not complete");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
